// File: rtl/wb_buf_stage.sv
// Writeback stage: in-order retire buffer between MEM and the register file,
// with operand forwarding to decode. Optional retire counter: WS_RETIRE_CNT_EN.
module wb_buf_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ms_to_ws_valid,
  input  logic                   ms_gr_we,
  input  logic [ADDR_W-1:0]      ms_dest,
  input  logic [DATA_W-1:0]      ms_result,
  input  logic [PC_W-1:0]        ms_pc,
  output logic                   ws_allowin,
  input  logic                   rf_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      ds_rs1,
  input  logic [ADDR_W-1:0]      ds_rs2,
  output logic                   fwd1_hit,
  output logic [DATA_W-1:0]      fwd1_data,
  output logic                   fwd2_hit,
  output logic [DATA_W-1:0]      fwd2_data,
  output logic [$clog2(DEPTH):0] ws_count,
`ifdef WS_RETIRE_CNT_EN
  output logic [31:0]            ws_retire_cnt,
`endif
  output logic [PC_W-1:0]        debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [ADDR_W-1:0]      debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [DEPTH-1:0]  valid_r;
  logic              gr_we_r  [DEPTH];
  logic [ADDR_W-1:0] dest_r   [DEPTH];
  logic [DATA_W-1:0] result_r [DEPTH];
  logic [PC_W-1:0]   pc_r     [DEPTH];

  logic head_valid_s;
  logic retire_s;
  logic allowin_s;
  logic push_s;

  // Handshake: retire decision, space check and push qualification
  always_comb begin
    head_valid_s = valid_r[head_r];
    retire_s     = head_valid_s && (rf_ready || !gr_we_r[head_r]);
    allowin_s    = (count_r < CNT_W'(DEPTH)) || retire_s;
    push_s       = ms_to_ws_valid && allowin_s;
  end

  // Pointers, occupancy and valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else begin
      // Clear before set: on a full buffer head==tail, and the new entry must win.
      if (retire_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1);
      end
      if (push_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_W'(1);
      end
      case ({push_s, retire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload; qualified by valid_r so it needs no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      gr_we_r[tail_r]  <= ms_gr_we;
      dest_r[tail_r]   <= ms_dest;
      result_r[tail_r] <= ms_result;
      pc_r[tail_r]     <= ms_pc;
    end
  end

  // RF write port and debug trace, both driven from the head entry
  always_comb begin
    ws_allowin = allowin_s;
    ws_count   = count_r;
    rf_we      = head_valid_s && gr_we_r[head_r] && rf_ready;
    rf_waddr   = head_valid_s ? dest_r[head_r]   : {ADDR_W{1'b0}};
    rf_wdata   = head_valid_s ? result_r[head_r] : {DATA_W{1'b0}};
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_pc       = retire_s ? pc_r[head_r]     : {PC_W{1'b0}};
    debug_wb_rf_wnum  = retire_s ? dest_r[head_r]   : {ADDR_W{1'b0}};
    debug_wb_rf_wdata = retire_s ? result_r[head_r] : {DATA_W{1'b0}};
  end

  // Forwarding: walk oldest to youngest so the youngest match is kept
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             m1;
    logic             m2;
    fwd1_hit  = 1'b0;
    fwd1_data = {DATA_W{1'b0}};
    fwd2_hit  = 1'b0;
    fwd2_data = {DATA_W{1'b0}};
    idx       = head_r;
    m1        = 1'b0;
    m2        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_r + PTR_W'(i);
      m1  = valid_r[idx] && gr_we_r[idx] && (dest_r[idx] == ds_rs1) &&
            (ds_rs1 != {ADDR_W{1'b0}});
      m2  = valid_r[idx] && gr_we_r[idx] && (dest_r[idx] == ds_rs2) &&
            (ds_rs2 != {ADDR_W{1'b0}});
      fwd1_hit  = fwd1_hit | m1;
      fwd1_data = m1 ? result_r[idx] : fwd1_data;
      fwd2_hit  = fwd2_hit | m2;
      fwd2_data = m2 ? result_r[idx] : fwd2_data;
    end
  end

`ifdef WS_RETIRE_CNT_EN
  logic [31:0] retire_cnt_r;

  // Free-running retire counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_r <= 32'd0;
    end else if (retire_s) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end
  end

  assign ws_retire_cnt = retire_cnt_r;
`endif

endmodule
